// File: rtl/clock_defs.sv
// -----------------------------------------------------------------------------
// clock_defs
//   Shared definitions for the clock time-setting path: sequencer state
//   encodings, display field-select codes, timeout counter width and a small
//   helper that sizes free-running cycle counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package clock_defs;

  // Width of the set-mode inactivity counter (TIMEOUT_S lives in 1..15).
  localparam int TIMEOUT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  // Display field-select codes.
  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  // Bits needed by a counter that runs 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Field highlighted by the display while in a given state.
  function automatic logic [1:0] field_of(input state_t st);
    logic [1:0] f;
    case (st)
      ST_SET_HOUR: f = FIELD_HOUR;
      ST_SET_MIN:  f = FIELD_MIN;
      default:     f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// -----------------------------------------------------------------------------
// btn_repeat
//   Rising-edge detector with optional auto-repeat for a debounced button.
//   The button level is registered twice; a press is a 0->1 step between the
//   two registered copies, so a level first sampled at edge k shows up on
//   o_pulse during the cycle after edge k (the parent registers it at k+1).
//
//   Optional feature (compile-time macro ADJ_AUTO_REPEAT_EN):
//     defined   - while the button stays high, a further strobe fires
//                 REPEAT_DELAY cycles after the press strobe, then every
//                 REPEAT_PERIOD cycles.
//     undefined - one strobe per press; the repeat counter is not built.
//
// Ports
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   i_btn    in  debounced button level
//   i_clear  in  cancel the current press: masks this cycle's strobe and
//                stops auto-repeat until the button is released and
//                pressed again
//   o_pulse  out combinational one-cycle strobe (press or repeat)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module btn_repeat
  import clock_defs::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_clear,
  output logic o_pulse
);

  generate
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("btn_repeat: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end
  endgenerate

  logic r_lvl;
  logic r_lvl_d;
  logic w_rise;

  assign w_rise = r_lvl & ~r_lvl_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl   <= 1'b0;
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl   <= i_btn;
      r_lvl_d <= r_lvl;
    end
  end

`ifdef ADJ_AUTO_REPEAT_EN
  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = cnt_width(MAX_CNT);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;   // repeat armed for the current press
  logic             r_first;    // next repeat is the first one (uses DELAY)
  logic             w_rep_fire;

  // The counter starts at 0 on the edge that registers the press strobe, so
  // reaching LAST on a later edge places the repeat exactly DELAY (or
  // PERIOD) cycles after the previous strobe.
  assign w_rep_fire = r_active & r_lvl &
                      (r_cnt == (r_first ? DELAY_LAST : PERIOD_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_first  <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_first  <= 1'b0;
    end else if (w_rise) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_first  <= 1'b1;
    end else if (!r_lvl) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_first  <= 1'b0;
    end else if (r_active) begin
      if (w_rep_fire) begin
        r_cnt   <= '0;
        r_first <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = ~i_clear & (w_rise | w_rep_fire);
`else
  assign o_pulse = ~i_clear & w_rise;
`endif

endmodule

// File: rtl/adjust_seq.sv
// -----------------------------------------------------------------------------
// adjust_seq
//   Time-setting mode sequencer. Mode presses walk RUN -> SET_HOUR ->
//   SET_MIN -> RUN; increment presses (with optional auto-repeat) produce
//   hour/minute +1 pulses in the matching set state. A set state falls back
//   to RUN after TIMEOUT_S seconds without a press, and the selected field
//   blinks with a BLINK_HALF-cycle half-period.
//
//   Optional feature (compile-time macro ADJ_AUTO_REPEAT_EN): increment
//   auto-repeat inside btn_repeat. Without it, one pulse per press.
//
// Ports
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   mode_btn   in  debounced mode button level
//   inc_btn    in  debounced increment button level
//   sec_tick   in  1-cycle 1 Hz pulse
//   run_en     out timekeeping enable (1 in RUN)
//   hour_inc   out 1-cycle hour +1 pulse
//   min_inc    out 1-cycle minute +1 pulse
//   sec_clr    out 1-cycle seconds clear (on SET_MIN -> RUN by mode press)
//   field_sel  out 00 none, 01 hour, 10 minute
//   blank      out 1 = blank the selected field
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module adjust_seq
  import clock_defs::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int TIMEOUT_S     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       sec_tick,
  output logic       run_en,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic [1:0] field_sel,
  output logic       blank
);

  generate
    if (TIMEOUT_S < 1 || TIMEOUT_S > 15 || BLINK_HALF < 1) begin : g_bad_param
      $error("adjust_seq: TIMEOUT_S must be 1..15 and BLINK_HALF at least 1");
    end
  endgenerate

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT_S);
  localparam int BLINK_W = cnt_width(BLINK_HALF);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  // ---------------------------------------------------------------------------
  // Button front end
  // ---------------------------------------------------------------------------
  logic r_mode_lvl;
  logic r_mode_lvl_d;
  logic w_mode_rise;
  logic w_inc_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_lvl   <= 1'b0;
      r_mode_lvl_d <= 1'b0;
    end else begin
      r_mode_lvl   <= mode_btn;
      r_mode_lvl_d <= r_mode_lvl;
    end
  end

  assign w_mode_rise = r_mode_lvl & ~r_mode_lvl_d;

  // The mode press doubles as the repeat clear: it masks a coincident
  // increment and suppresses repeats of a button held across the mode change.
  btn_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_inc_repeat (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (inc_btn),
    .i_clear (w_mode_rise),
    .o_pulse (w_inc_pulse)
  );

  // ---------------------------------------------------------------------------
  // Sequencer state and counters
  // ---------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_next;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [TIMEOUT_W-1:0] w_to_cnt_next;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic [BLINK_W-1:0]   w_blink_cnt_next;
  logic                 w_blank_next;
  logic                 w_hour_inc_next;
  logic                 w_min_inc_next;
  logic                 w_sec_clr_next;
  logic                 w_press;
  logic                 w_entry;
  logic                 w_timed_out;

  logic                 r_run_en;
  logic                 r_hour_inc;
  logic                 r_min_inc;
  logic                 r_sec_clr;
  logic [1:0]           r_field_sel;
  logic                 r_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_to_cnt    <= '0;
      r_blink_cnt <= '0;
      r_run_en    <= 1'b1;
      r_hour_inc  <= 1'b0;
      r_min_inc   <= 1'b0;
      r_sec_clr   <= 1'b0;
      r_field_sel <= FIELD_NONE;
      r_blank     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_to_cnt    <= w_to_cnt_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_run_en    <= (w_state_next == ST_RUN);
      r_hour_inc  <= w_hour_inc_next;
      r_min_inc   <= w_min_inc_next;
      r_sec_clr   <= w_sec_clr_next;
      r_field_sel <= field_of(w_state_next);
      r_blank     <= w_blank_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_hour_inc_next = 1'b0;
    w_min_inc_next  = 1'b0;
    w_sec_clr_next  = 1'b0;
    w_press         = w_mode_rise | w_inc_pulse;
    w_timed_out     = (r_to_cnt == TIMEOUT_V);

    // Priority within a set state: mode press, then increment, then timeout.
    case (r_state)
      ST_RUN: begin
        if (w_mode_rise) begin
          w_state_next = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        if (w_mode_rise) begin
          w_state_next = ST_SET_MIN;
        end else if (w_inc_pulse) begin
          w_hour_inc_next = 1'b1;
        end else if (w_timed_out) begin
          w_state_next = ST_RUN;
        end
      end
      ST_SET_MIN: begin
        if (w_mode_rise) begin
          w_state_next   = ST_RUN;
          w_sec_clr_next = 1'b1;
        end else if (w_inc_pulse) begin
          w_min_inc_next = 1'b1;
        end else if (w_timed_out) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    w_entry = (w_state_next != r_state);

    // Inactivity counter: only live while staying in a set state; saturates
    // at the limit so a stray tick cannot wrap it past the compare.
    w_to_cnt_next = r_to_cnt;
    if (w_state_next == ST_RUN || w_entry || w_press) begin
      w_to_cnt_next = '0;
    end else if (sec_tick && !w_timed_out) begin
      w_to_cnt_next = r_to_cnt + 1'b1;
    end

    // Blink: restart dark-free on every set-state entry, idle in RUN.
    w_blink_cnt_next = r_blink_cnt;
    w_blank_next     = r_blank;
    if (w_state_next == ST_RUN || w_entry) begin
      w_blink_cnt_next = '0;
      w_blank_next     = 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_next = '0;
      w_blank_next     = ~r_blank;
    end else begin
      w_blink_cnt_next = r_blink_cnt + 1'b1;
    end
  end

  assign run_en    = r_run_en;
  assign hour_inc  = r_hour_inc;
  assign min_inc   = r_min_inc;
  assign sec_clr   = r_sec_clr;
  assign field_sel = r_field_sel;
  assign blank     = r_blank;

endmodule

// File: doc/adjust_seq.md
# adjust_seq

Mode sequencer for the clock's time-setting path. It turns two debounced push-buttons into mode transitions and increment pulses: a mode button and an increment button with optional auto-repeat. It sequences the hour/minute counters through RUN → SET_HOUR → SET_MIN → RUN, gates normal timekeeping, and drives field blanking for the display. It sits between the debounce stage and the time counters / display mux.

## Interface
- `REPEAT_DELAY`, 25_000_000: cycles `inc_btn` must stay high before the first auto-repeat pulse.
- `REPEAT_PERIOD`, 5_000_000: cycles between subsequent auto-repeat pulses.
- `BLINK_HALF`, 12_500_000: cycles per half-period of the `blank` toggle.
- `TIMEOUT_S`, 10: `sec_tick` pulses without a button press before a set state falls back to RUN; width 4 bits, range 1..15.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode_btn` in 1: debounced mode button level.
- `inc_btn` in 1: debounced increment button level.
- `sec_tick` in 1: 1-cycle 1 Hz pulse from the divider; free-running in all modes.
- `run_en` out 1: timekeeping enable.
- `hour_inc` out 1: 1-cycle hour +1 pulse.
- `min_inc` out 1: 1-cycle minute +1 pulse.
- `sec_clr` out 1: 1-cycle seconds-clear pulse.
- `field_sel` out 2: 00 = none, 01 = hour, 10 = minute.
- `blank` out 1: 1 = blank the selected field.

## Operation
- States:
  - RUN: `run_en` = 1, `field_sel` = 00.
  - SET_HOUR: `run_en` = 0, `field_sel` = 01.
  - SET_MIN: `run_en` = 0, `field_sel` = 10.
- Mode press is a rising edge of `mode_btn`. Transitions: RUN→SET_HOUR, SET_HOUR→SET_MIN, SET_MIN→RUN.
  - SET_MIN→RUN on a mode press also pulses `sec_clr`.
- Increment press is a rising edge of `inc_btn`.
  - SET_HOUR: pulse `hour_inc`.
  - SET_MIN: pulse `min_inc`.
  - RUN: ignored.
- Auto-repeat:
  - While `inc_btn` stays high, a further pulse fires after `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles.
  - Releasing `inc_btn` clears the repeat counter.
- Timeout:
  - In a set state, a 4-bit counter increments on each `sec_tick` and clears on every mode or increment press and on state entry.
  - Reaching `TIMEOUT_S` forces RUN with no `sec_clr` pulse.
  - Auto-repeat pulses also clear the counter.
- Blink:
  - `blank` toggles every `BLINK_HALF` cycles in set states.
  - On entry to a set state, the blink counter clears and `blank` = 0.
  - In RUN, `blank` = 0.
- Simultaneous events:
  - Mode press and increment press in the same cycle: the mode press wins and no increment pulse is issued.
  - Mode press while `inc_btn` is held: the repeat counter is cleared and further increments are suppressed until `inc_btn` is released and pressed again.
  - Timeout and a press in the same cycle: the press wins and the timeout counter clears.
- `hour_inc`, `min_inc` and `sec_clr` are mutually exclusive and never high in RUN, except `sec_clr` on its exit cycle.
- The block does no increment arithmetic; wrap-around belongs to the counters.

## Timing
- Reset values: state RUN, `run_en` = 1, `hour_inc` = 0, `min_inc` = 0, `sec_clr` = 0, `field_sel` = 00, `blank` = 0; all internal counters 0.
- All outputs are registered.
- An input first sampled high at edge k produces its pulse or state change visible after edge k+1; latency is 1 cycle after sampling.
- Auto-repeat: the first repeat pulse follows the press pulse by exactly `REPEAT_DELAY` cycles; later repeat pulses are spaced exactly `REPEAT_PERIOD` cycles apart.
- Timeout: the state change occurs 1 cycle after the `sec_tick` that reaches `TIMEOUT_S`.
- Reset mid-operation: outputs return to reset values immediately and asynchronously; no pulse is emitted after release.

## Configuration
- `ADJ_AUTO_REPEAT_EN`
  - Defined: auto-repeat as above.
  - Undefined: exactly one increment pulse per press, the repeat counter is removed, and `REPEAT_DELAY` / `REPEAT_PERIOD` are unused.

## Structure
- Shared package `clock_defs`:
  - state encodings `ST_RUN` = 2'd0, `ST_SET_HOUR` = 2'd1, `ST_SET_MIN` = 2'd2;
  - `field_sel` codes;
  - `TIMEOUT_S` width constant.
- One sub-module, `btn_repeat`: rising-edge detect plus the auto-repeat pulse generator, with a `clear` input for mode-press suppression. It is instantiated for `inc_btn` only.
- The mode-edge detect, FSM, timeout counter and blink counter live in `adjust_seq`.

## Test plan
- Reset, then idle 100 cycles → `run_en` = 1, `field_sel` = 00, no pulses.
- 3 mode presses → `field_sel` goes 01, 10, 00; `run_en` goes 0, 0, 1; exactly one `sec_clr` pulse, on the third press.
- SET_HOUR, one inc press → exactly one `hour_inc`; in RUN, the same press gives no pulse.
- `REPEAT_DELAY` = 20, `REPEAT_PERIOD` = 5, `inc_btn` held 40 cycles in SET_MIN → `min_inc` at press+1, +21, +26, +31, +36; with `ADJ_AUTO_REPEAT_EN` undefined → only press+1.
- SET_MIN, 10 `sec_tick` pulses with no press → RUN 1 cycle after the 10th tick, no `sec_clr`; a press at tick 9 restarts the count.
- Mode and inc rising in the same cycle in SET_HOUR → SET_MIN, no `hour_inc`; `rst_n` low mid-repeat → outputs at reset values, no trailing pulse.
